seven_segment_scan_driver: RTL and testbench
============================================

// Module: seven_segment_scan_driver
// PURPOSE
//  Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus.
//  - Accepts a packed hex word through a valid/ready load port.
//  - Holds the word in a shadow register and commits it only at frame boundaries, so no digit tears.
//  - Scans the digits at a prescaled rate and inserts an anti-ghosting blank at the start of each slot.
//  - Sits between the datapath and the board pins.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned, 1..8
//  REFRESH_DIV   50000  clk cycles per digit slot, >=2
//  GHOST_CYCLES  2      cycles at slot start with all anodes off, < REFRESH_DIV
// PORTS
//  clk         in   1              system clock, rising edge
//  rst_n       in   1              synchronous reset, active-low
//  load_valid  in   1              new display word offered
//  load_ready  out  1              shadow register empty; load accepted when valid & ready
//  load_value  in   4*NUM_DIGITS   hex nibbles; digit i = [4i+3:4i], digit 0 = rightmost
//  load_blank  in   NUM_DIGITS     1 = digit i forced dark
//  load_dp     in   NUM_DIGITS     1 = decimal point of digit i lit
//  seg         out  7              segments a..g = bit0..bit6, active-low
//  seg_dp      out  1              decimal point, active-low
//  an          out  NUM_DIGITS     digit enables, active-low, at most one low
//  frame_done  out  1              1-cycle pulse when digit NUM_DIGITS-1 slot ends
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    - Counters: prescaler=0, digit idx=0.
//    - Registers: display and shadow registers=0; shadow marked empty.
//    - Outputs: seg=7'h7F, seg_dp=1, an=all 1, frame_done=0, load_ready=1.
//    - Reset mid-frame discards any pending word.
//  - Prescaler:
//    - Counts 0..REFRESH_DIV-1.
//    - tick = (cnt==REFRESH_DIV-1); cnt wraps to 0 on tick.
//    - On tick, idx advances and wraps NUM_DIGITS-1 -> 0.
//  - Load handshake:
//    - load_ready = ~pending.
//    - On valid & ready, value/blank/dp are captured into the shadow register and pending is set.
//    - valid while not ready has no effect; the producer holds its data.
//  - Commit:
//    - On a tick with idx==NUM_DIGITS-1 and pending=1: display <= shadow, pending cleared.
//    - load_ready rises the cycle after commit.
//    - A load accepted in the same cycle as a wrap tick (pending was 0) is committed at the next wrap, not that one.
//  - Outputs are registered, 1-cycle latency from (cnt, idx, display):
//    - an[idx] low iff cnt >= GHOST_CYCLES; all other an bits high.
//    - seg = font(display nibble idx); 7'h7F if blank[idx].
//    - seg_dp = ~dp[idx]. The dp is not blanked by blank[idx].
//  - Font (active-low):
//    - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//    - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
//  - frame_done:
//    - Registered, asserted the cycle after the wrap tick, together with the first slot of digit 0.
//  - NUM_DIGITS=1: idx stays 0; every tick is a wrap and commit point.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN
//  - Defined:
//    - Digit i>0 is additionally dark when its nibble and all higher nibbles are 0.
//    - Digit 0 is never auto-blanked.
//    - Decimal points are unaffected.
//  - Undefined: only load_blank darkens digits; zeros display as 0.
// STRUCTURE
//  - Package seg7_pkg holds:
//    - SEG_BLANK=7'h7F.
//    - The 16-entry font constant.
//    - A nibble_t typedef.
//    - Parameter-range check constants.
//  - Sub-module seven_segment_font: combinational nibble -> active-low segments from the package table.
//  - Sequential logic (prescaler, scan index, shadow/display registers, output registers) stays in this module.
// TESTING
//  Bench config: NUM_DIGITS=4, REFRESH_DIV=4, GHOST_CYCLES=1.
//  1. Reset with load_valid=1 -> all outputs at reset values; load_ready=1; no capture while rst_n=0.
//  2. Load 16'h12AF, blank=0, dp=4'b0010 -> display changes only after the next frame_done.
//     - Digit 0 seg=0E, digit 1 seg=08 with seg_dp=0, digit 2 seg=24, digit 3 seg=79.
//     - an pattern per slot: 1111 for 1 cycle, then 1110/1101/1011/0111 for 3 cycles.
//  3. Two loads back-to-back before a wrap -> second held off (load_ready=0) until the commit.
//     - The first word displays for a full frame, then the second.
//  4. Load accepted on the exact wrap-tick cycle -> not committed that frame; commits at the following wrap.
//  5. blank=4'b1000, value 16'h0005 -> digit 3 seg=7F.
//     - With LEADING_ZERO_BLANK_EN: digits 3..1 dark, digit 0 shows 12.
//  6. rst_n low mid-frame with pending word -> outputs reset next edge, pending discarded, idx restarts at 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Active-low font table and parameter limits live here.
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][6:0] FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam int MIN_DIGITS      = 1;
  localparam int MAX_DIGITS      = 8;
  localparam int MIN_REFRESH_DIV = 2;

endpackage

// File: rtl/seven_segment_font.sv
// Combinational hex nibble to active-low segment decoder.
// Bit 0 = segment a .. bit 6 = segment g.
module seven_segment_font
  import seg7_pkg::*;
(
  input  nibble_t    nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = FONT[nib_i];

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Multiplexed common-anode seven-segment driver with frame-aligned commit.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits above digit 0.
module seven_segment_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GHOST_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GHOST = CW'(GHOST_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS ||
      REFRESH_DIV < MIN_REFRESH_DIV ||
      GHOST_CYCLES >= REFRESH_DIV) begin : g_param_err
    $error("seven_segment_scan_driver: parameter out of range");
  end

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         disp_val_q, sh_val_q;
  logic [NUM_DIGITS-1:0] disp_blk_q, sh_blk_q;
  logic [NUM_DIGITS-1:0] disp_dp_q, sh_dp_q;
  logic                  pend_q;

  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q;

  logic tick, wrap, accept, commit;

  assign tick   = (cnt_q == CNT_LAST);
  assign wrap   = tick && (idx_q == IDX_LAST);
  assign accept = load_valid && !pend_q;
  assign commit = wrap && pend_q;

  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign idx_d = !tick ? idx_q :
                 (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  nibble_t    nib;
  logic       dark;
  logic [6:0] font_seg;
`ifdef LEADING_ZERO_BLANK_EN
  logic       lz_zero;
`endif

  always_comb begin
    nib      = '0;
    dark     = 1'b0;
    seg_dp_d = 1'b1;
    an_d     = '1;
`ifdef LEADING_ZERO_BLANK_EN
    lz_zero  = 1'b1;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      lz_zero = lz_zero && (disp_val_q[4*i +: 4] == 4'h0);
`endif
      if (idx_q == IW'(i)) begin
        nib      = disp_val_q[4*i +: 4];
        dark     = disp_blk_q[i];
        seg_dp_d = ~disp_dp_q[i];
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && lz_zero) dark = 1'b1;
`endif
        // Anodes stay off during the ghost window at slot start
        if (cnt_q >= CNT_GHOST) an_d[i] = 1'b0;
      end
    end
  end

  seven_segment_font u_font (
    .nib_i (nib),
    .seg_o (font_seg)
  );

  assign seg_d = dark ? SEG_BLANK : font_seg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_blk_q <= '0;
      disp_dp_q  <= '0;
      sh_val_q   <= '0;
      sh_blk_q   <= '0;
      sh_dp_q    <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_BLANK;
      seg_dp_q   <= 1'b1;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (commit) begin
        disp_val_q <= sh_val_q;
        disp_blk_q <= sh_blk_q;
        disp_dp_q  <= sh_dp_q;
        pend_q     <= 1'b0;
      end else if (accept) begin
        pend_q <= 1'b1;
      end
      if (accept) begin
        sh_val_q <= load_value;
        sh_blk_q <= load_blank;
        sh_dp_q  <= load_dp;
      end
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      an_q     <= an_d;
      fd_q     <= wrap;
    end
  end

  assign load_ready = ~pend_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: timeline model plus directed frames.
// Honours LEADING_ZERO_BLANK_EN when defined.
module tb_seven_segment_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int G  = 1;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_value = '0;
  logic [3:0]  load_blank = '0;
  logic [3:0]  load_dp = '0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        frame_done;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seven_segment_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .GHOST_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_blank (load_blank),
    .load_dp    (load_dp),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .an         (an),
    .frame_done (frame_done)
  );

  logic [6:0] font_tb [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic cmp(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Timeline model: n counts cycles since reset release
  int          n;
  int          pos, dig;
  bit          m_live = 1'b0;
  bit          m_pend, m_wrap, m_dark;
  logic [15:0] m_val, s_val;
  logic [3:0]  m_blk, s_blk, m_dp, s_dp;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [3:0]  e_an;

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; m_pend = 0;
      m_val = '0; m_blk = '0; m_dp = '0;
      s_val = '0; s_blk = '0; s_dp = '0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      pos = n % RD;
      dig = (n / RD) % N;
      m_dark = m_blk[dig] ||
               (LZB && dig > 0 && (m_val >> (4 * dig)) == 16'h0);
      e_seg = m_dark ? 7'h7F : font_tb[m_val[4*dig +: 4]];
      e_dp  = ~m_dp[dig];
      e_an  = (pos >= G) ? ~(4'b0001 << dig) : 4'hF;
      m_wrap = (pos == RD - 1) && (dig == N - 1);
      e_fd  = m_wrap;
      if (m_wrap && m_pend) begin
        m_val = s_val; m_blk = s_blk; m_dp = s_dp; m_pend = 0;
      end else if (load_valid && !m_pend) begin
        s_val = load_value; s_blk = load_blank; s_dp = load_dp;
        m_pend = 1;
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      cmp("model_an", an, e_an);
      cmp("model_seg", seg, e_seg);
      cmp("model_dp", seg_dp, e_dp);
      cmp("model_fd", frame_done, e_fd);
      cmp("model_ready", load_ready, !m_pend);
    end
  end

  task automatic wait_fd(output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (frame_done) seen = 1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL wait_fd: no frame_done within 64 cycles");
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b,
                         input logic [3:0] d);
    bit done = 0;
    load_value = v; load_blank = b; load_dp = d;
    load_valid = 1'b1;
    for (int k = 0; k < 80 && !done; k++) begin
      if (load_ready) done = 1;
      @(negedge clk);
    end
    load_valid = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL do_load: load_ready never rose (value %0h)", v);
    end
  endtask

  // Called at the frame_done negedge; checks the following 16 cycles
  task automatic check_frame(input string tag,
                             input logic [3:0][6:0] segs,
                             input logic [3:0] dpn);
    logic [3:0] ea;
    for (int d = 0; d < N; d++) begin
      for (int c = 0; c < RD; c++) begin
        @(negedge clk);
        ea = (c < G) ? 4'hF : ~(4'b0001 << d);
        cmp({tag, "_an"}, an, ea);
        cmp({tag, "_seg"}, seg, segs[d]);
        cmp({tag, "_dp"}, seg_dp, dpn[d]);
      end
    end
  endtask

  logic [3:0][6:0] exp5, exp6;
  int cyc;

  initial begin
    // 1: reset with valid high
    rst_n = 1'b0;
    load_valid = 1'b1;
    load_value = 16'hBEEF;
    repeat (3) @(negedge clk);
    cmp("t1_seg", seg, 7'h7F);
    cmp("t1_dp", seg_dp, 1'b1);
    cmp("t1_an", an, 4'hF);
    cmp("t1_fd", frame_done, 1'b0);
    cmp("t1_ready", load_ready, 1'b1);
    load_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    cmp("t1_ready_after", load_ready, 1'b1);
    cmp("t1_seg_zero", seg, 7'h40);
    cmp("t1_an_ghost", an, 4'hF);

    // 2: simple load, visible after next frame boundary
    do_load(16'h12AF, 4'b0000, 4'b0010);
    wait_fd(cyc);
    check_frame("t2", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1101);

    // 3: back-to-back loads
    do_load(16'h5789, 4'b0000, 4'b0000);
    cmp("t3_ready_low", load_ready, 1'b0);
    fork
      do_load(16'hCDE0, 4'b0000, 4'b0001);
      begin
        wait_fd(cyc);
        check_frame("t3a", {7'h12, 7'h78, 7'h00, 7'h10}, 4'b1111);
      end
    join
    wait_fd(cyc);
    check_frame("t3b", {7'h46, 7'h21, 7'h06, 7'h40}, 4'b1110);

    // 4: load accepted on the wrap tick itself
    repeat (RD * N - 1) @(negedge clk);
    load_value = 16'h3456; load_blank = '0; load_dp = '0;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    cmp("t4_fd_align", frame_done, 1'b1);
    cmp("t4_ready_low", load_ready, 1'b0);
    check_frame("t4old", {7'h46, 7'h21, 7'h06, 7'h40}, 4'b1110);
    check_frame("t4new", {7'h30, 7'h19, 7'h12, 7'h02}, 4'b1111);

    // 5: explicit blank of digit 3
    do_load(16'h0005, 4'b1000, 4'b0000);
    wait_fd(cyc);
    exp5 = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h12}
               : {7'h7F, 7'h40, 7'h40, 7'h12};
    check_frame("t5", exp5, 4'b1111);

    // 6: reset mid-frame discards pending word
    do_load(16'h8888, 4'b0000, 4'b1111);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    cmp("t6_seg", seg, 7'h7F);
    cmp("t6_an", an, 4'hF);
    cmp("t6_dp", seg_dp, 1'b1);
    cmp("t6_fd", frame_done, 1'b0);
    cmp("t6_ready", load_ready, 1'b1);
    rst_n = 1'b1;
    wait_fd(cyc);
    cmp("t6_fd_latency", cyc, RD * N);
    exp6 = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h40}
               : {7'h40, 7'h40, 7'h40, 7'h40};
    check_frame("t6", exp6, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
